// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a length-prefixed image into the byte-addressed IMEM and holds the core until it is in.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_NBYTE = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    // Handshake: a stream byte is consumed on every rising edge where in_valid && in_ready;
    // in_valid while in_ready is low simply stalls, the byte is presented again later.
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE} state_t;
`endif

    localparam logic [31:0] MEM_LIM = MEM_NBYTE;

    // state is the FSM register; checkers may bind to it directly.
    state_t      state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] len_full;
    logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum;
`endif

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len[7:0]};

    // Status outputs are pure decodes of the state register.
    assign in_ready = (state != IDLE) && (state != DONE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEN_LO;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        cnt      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        if ({16'd0, len_full} > MEM_LIM) err <= 1'b1;
                        if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= DONE;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Bytes beyond the memory are consumed but never written; address/data hold.
                        if ({16'd0, cnt} < MEM_LIM) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(cnt);
                            mem_wdata <= in_data;
                        end
                        cnt <= cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + in_data;
`endif
                        if (cnt == len - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) begin
                        if (in_data != sum) err <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    // Release the core only when the image arrived intact.
                    cpu_hold <= err;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
